// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared types and default constants for the two-master bus
//               arbiter: FSM state encoding, default bus widths and the base
//               address of the memory-mapped IO region.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    localparam int C_ADDR_W_DEF  = 8;
    localparam int C_DATA_W_DEF  = 8;
    localparam int C_IO_BASE_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-requester round-robin pick. A lone
//               requester always wins; on contention the pointer decides.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       gnt_id_o,
    output logic       gnt_vld_o
);

    // Pick the winner from the request pair and the priority pointer
    always_comb begin
        gnt_vld_o = |req_i;
        gnt_id_o  = 1'b0;
        case (req_i)
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ptr_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master, one-slave bus arbiter. Round-robin grant in IDLE,
//               one-cycle slave strobe, one wait cycle for the registered
//               slave read data, then a one-cycle done pulse. Master 1 can
//               be fenced off the IO region, in which case the transfer runs
//               its full length without a strobe and ends with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W_DEF,
    parameter int DATA_W     = C_DATA_W_DEF,
    parameter int IO_BASE    = C_IO_BASE_DEF,
    parameter bit M1_IO_LOCK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    // master 0
    input  logic              m0_write,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    // master 1
    input  logic              m1_write,
    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    // slave
    output logic              s_write,
    output logic              s_read,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata
);

    localparam logic [ADDR_W-1:0] C_IO_BASE = ADDR_W'(IO_BASE);

    arb_state_t state_q;
    logic       ptr_q;      // master preferred on the next contended grant
    logic       id_q;       // master owning the transfer in flight
    logic       wr_q;       // transfer in flight is a write
    logic       lock_q;     // transfer in flight was fenced off the IO region

    logic [1:0]        w_req;
    logic              w_gnt_id;
    logic              w_gnt_vld;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_locked;

    assign w_req = {m1_write | m1_read, m0_write | m0_read};

    rr_pick2 u_pick (
        .req_i     (w_req),
        .ptr_i     (ptr_q),
        .gnt_id_o  (w_gnt_id),
        .gnt_vld_o (w_gnt_vld)
    );

    // Route the winning master's request; a simultaneous read+write is a write
    always_comb begin
        w_sel_write = w_gnt_id ? m1_write : m0_write;
        w_sel_addr  = w_gnt_id ? m1_addr  : m0_addr;
        w_sel_wdata = w_gnt_id ? m1_wdata : m0_wdata;
        w_locked    = M1_IO_LOCK && w_gnt_id && (w_sel_addr >= C_IO_BASE);
    end

    // Transfer sequencer: grant, strobe, wait for slave data, report done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            wr_q     <= 1'b0;
            lock_q   <= 1'b0;
            s_write  <= 1'b0;
            s_read   <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m0_rdata <= '0;
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m1_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        state_q <= ST_ISSUE;
                        ptr_q   <= ~w_gnt_id;
                        id_q    <= w_gnt_id;
                        wr_q    <= w_sel_write;
                        lock_q  <= w_locked;
                        s_addr  <= w_sel_addr;
                        s_wdata <= w_sel_wdata;
                        // A fenced transfer still runs its slot but never
                        // reaches the slave.
                        s_write <= w_sel_write & ~w_locked;
                        s_read  <= ~w_sel_write & ~w_locked;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    s_write <= 1'b0;
                    s_read  <= 1'b0;
                end
                ST_WAIT: begin
                    state_q <= ST_DONE;
                    // Slave read data is valid this cycle; writes leave rdata alone
                    if (lock_q) begin
                        m1_rdata <= '0;
                    end else if (!wr_q) begin
                        if (id_q) begin
                            m1_rdata <= s_rdata;
                        end else begin
                            m0_rdata <= s_rdata;
                        end
                    end
                    if (id_q) begin
                        m1_done <= 1'b1;
                        m1_err  <= lock_q;
                    end else begin
                        m0_done <= 1'b1;
                        m0_err  <= lock_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    m0_done <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_done <= 1'b0;
                    m1_err  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios
//               add hand-computed literal expectations. The slave answers a
//               read of address A with A ^ 0x20 one cycle after the strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_write = 1'b0, m0_read = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0;
    logic [7:0] m0_rdata;
    logic       m0_done, m0_err;
    logic       m1_write = 1'b0, m1_read = 1'b0;
    logic [7:0] m1_addr = '0, m1_wdata = '0;
    logic [7:0] m1_rdata;
    logic       m1_done, m1_err;
    logic       s_write, s_read;
    logic [7:0] s_addr, s_wdata;
    logic [7:0] s_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .IO_BASE    (128),
        .M1_IO_LOCK (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_write (m0_write),
        .m0_read  (m0_read),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_done  (m0_done),
        .m0_err   (m0_err),
        .m1_write (m1_write),
        .m1_read  (m1_read),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_done  (m1_done),
        .m1_err   (m1_err),
        .s_write  (s_write),
        .s_read   (s_read),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata)
    );

    // Slave: registered read data, a fixed function of the address
    always @(posedge clk) begin
        if (s_read) s_rdata <= s_addr ^ 8'h20;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: tracks the transfer in flight by how many
    // edges have passed since its grant and predicts every output.
    // ------------------------------------------------------------------
    bit         started = 1'b0;
    int         since   = 0;          // 0 = bus free, else edges since grant
    bit         m_ptr, m_id, m_wr, m_lock, r0, r1;
    logic [7:0] m_addr, m_wdata;
    logic       e_sw = 0, e_sr = 0, e_d0 = 0, e_d1 = 0, e_e0 = 0, e_e1 = 0;
    logic [7:0] e_saddr = 0, e_swdata = 0, e_rd0 = 0, e_rd1 = 0;

    always @(posedge clk) begin
        started = 1'b1;
        e_sw = 0; e_sr = 0; e_d0 = 0; e_d1 = 0; e_e0 = 0; e_e1 = 0;
        if (rst) begin
            since = 0; m_ptr = 0; e_rd0 = 0; e_rd1 = 0;
        end else if (since == 0) begin
            r0 = m0_write | m0_read;
            r1 = m1_write | m1_read;
            if (r0 || r1) begin
                m_id    = (r0 && r1) ? m_ptr : r1;
                m_ptr   = !m_id;
                m_wr    = m_id ? m1_write : m0_write;
                m_addr  = m_id ? m1_addr  : m0_addr;
                m_wdata = m_id ? m1_wdata : m0_wdata;
                m_lock  = m_id && (m_addr >= 8'd128);
                e_saddr = m_addr;
                e_swdata = m_wdata;
                if (!m_lock) begin
                    e_sw = m_wr;
                    e_sr = !m_wr;
                end
                since = 1;
            end
        end else if (since == 2) begin
            if (m_lock) e_rd1 = 8'h00;
            else if (!m_wr) begin
                if (m_id) e_rd1 = m_addr ^ 8'h20;
                else      e_rd0 = m_addr ^ 8'h20;
            end
            if (m_id) begin e_d1 = 1; e_e1 = m_lock; end
            else      begin e_d0 = 1; e_e0 = 1'b0;   end
            since = 3;
        end else if (since == 3) begin
            since = 0;
        end else begin
            since = since + 1;
        end
    end

    // Compare every cycle, mid-period
    always @(negedge clk) begin
        if (started) begin
            chk("s_write", s_write, e_sw);
            chk("s_read",  s_read,  e_sr);
            if (e_sw || e_sr) begin
                chk("s_addr",  s_addr,  e_saddr);
                chk("s_wdata", s_wdata, e_swdata);
            end
            chk("m0_done",  m0_done,  e_d0);
            chk("m0_err",   m0_err,   e_e0);
            chk("m0_rdata", m0_rdata, e_rd0);
            chk("m1_done",  m1_done,  e_d1);
            chk("m1_err",   m1_err,   e_e1);
            chk("m1_rdata", m1_rdata, e_rd1);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit m, input logic wr, input logic rd,
                           input logic [7:0] a, input logic [7:0] d);
        if (m) begin m1_write = wr; m1_read = rd; m1_addr = a; m1_wdata = d; end
        else   begin m0_write = wr; m0_read = rd; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic clr_req(input bit m);
        if (m) begin m1_write = 0; m1_read = 0; end
        else   begin m0_write = 0; m0_read = 0; end
    endtask

    // Wait (bounded) for master m's done; report latency and the strobe
    // cycle's slave bus. The request drops in the done cycle.
    task automatic wait_tx(input bit m, output int lat, output logic sw, output logic sr,
                           output logic [7:0] sa, output logic [7:0] sd);
        lat = -1; sw = 0; sr = 0; sa = 0; sd = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) begin sw = s_write; sr = s_read; sa = s_addr; sd = s_wdata; end
            if ((m ? m1_done : m0_done) === 1'b1) begin
                lat = n;
                break;
            end
        end
        clr_req(m);
    endtask

    task automatic run_tx(input bit m, input logic wr, input logic rd,
                          input logic [7:0] a, input logic [7:0] d, output int lat,
                          output logic sw, output logic sr,
                          output logic [7:0] sa, output logic [7:0] sd);
        tick();
        set_req(m, wr, rd, a, d);
        wait_tx(m, lat, sw, sr, sa, sd);
    endtask

    int         lat;
    logic       sw, sr;
    logic [7:0] sa, sd;
    logic [1:0] dn;

    initial begin
        // Request pending through reset must not be granted until rst drops
        set_req(0, 1, 0, 8'd128, 8'hE0);
        repeat (3) tick();
        chk("rst_s_write",  s_write,  1'b0);
        chk("rst_m0_done",  m0_done,  1'b0);
        chk("rst_m0_rdata", m0_rdata, 8'h00);
        rst = 1'b0;
        wait_tx(0, lat, sw, sr, sa, sd);
        chk("A_latency", lat, 3);
        chk("A_s_write", sw, 1'b1);
        chk("A_s_read",  sr, 1'b0);
        chk("A_s_addr",  sa, 8'd128);
        chk("A_s_wdata", sd, 8'hE0);
        chk("A_m0_err",  m0_err, 1'b0);

        // m0 read of 128: slave answers 0xA0
        run_tx(0, 0, 1, 8'd128, 8'h00, lat, sw, sr, sa, sd);
        chk("B_latency",  lat, 3);
        chk("B_s_read",   sr, 1'b1);
        chk("B_s_write",  sw, 1'b0);
        chk("B_m0_rdata", m0_rdata, 8'hA0);

        // Both masters reading from reset, held: m0, m1, m0, m1 four apart
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 0, 1, 8'h10, 8'h00);
        set_req(1, 0, 1, 8'h21, 8'h00);
        for (int n = 1; n <= 16; n++) begin
            tick();
            dn = {m1_done, m0_done};
            chk($sformatf("C_done_n%0d", n), dn,
                (n == 3 || n == 11) ? 2'b01 : (n == 7 || n == 15) ? 2'b10 : 2'b00);
        end
        clr_req(0);
        clr_req(1);
        chk("C_m0_rdata", m0_rdata, 8'h30);
        chk("C_m1_rdata", m1_rdata, 8'h01);

        // m1 write into the IO region is fenced
        run_tx(1, 1, 0, 8'd128, 8'h55, lat, sw, sr, sa, sd);
        chk("D1_latency",  lat, 3);
        chk("D1_s_write",  sw, 1'b0);
        chk("D1_m1_err",   m1_err, 1'b1);
        chk("D1_m1_rdata", m1_rdata, 8'h00);
        // Just below the IO base is allowed
        run_tx(1, 1, 0, 8'd127, 8'h66, lat, sw, sr, sa, sd);
        chk("D2_latency", lat, 3);
        chk("D2_s_write", sw, 1'b1);
        chk("D2_s_addr",  sa, 8'd127);
        chk("D2_m1_err",  m1_err, 1'b0);
        run_tx(1, 0, 1, 8'd127, 8'h00, lat, sw, sr, sa, sd);
        chk("D3_m1_rdata", m1_rdata, 8'h5F);
        run_tx(1, 0, 1, 8'd255, 8'h00, lat, sw, sr, sa, sd);
        chk("D4_s_read",   sr, 1'b0);
        chk("D4_m1_err",   m1_err, 1'b1);
        chk("D4_m1_rdata", m1_rdata, 8'h00);
        // Master 0 is never fenced; write+read together is a write
        run_tx(0, 1, 1, 8'd200, 8'h3C, lat, sw, sr, sa, sd);
        chk("D5_s_write", sw, 1'b1);
        chk("D5_s_read",  sr, 1'b0);
        chk("D5_m0_err",  m0_err, 1'b0);

        // Reset in WAIT aborts the transfer without a done
        tick();
        set_req(0, 0, 1, 8'h05, 8'h00);
        tick();
        chk("E_s_read_issue", s_read, 1'b1);
        tick();
        rst = 1'b1;
        clr_req(0);
        tick();
        chk("E_rst_m0_rdata", m0_rdata, 8'h00);
        chk("E_rst_m1_rdata", m1_rdata, 8'h00);
        chk("E_rst_s_addr",   s_addr,   8'h00);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("E_no_done", {m0_done, s_read, s_write}, 3'b000);
        end
        run_tx(1, 1, 0, 8'h10, 8'h77, lat, sw, sr, sa, sd);
        chk("E_m1_latency", lat, 3);
        chk("E_m1_s_write", sw, 1'b1);
        chk("E_m1_s_wdata", sd, 8'h77);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
